// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock with the round key
// expanded on the fly alongside the datapath.
module aes_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext,
  output logic         fault_flag
);

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned ROUND_W   = 4;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] rkey_q, rkey_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_d, done_d, fault_d;
  logic [BLOCK_W-1:0] ct_d;
  logic [BLOCK_W-1:0] shifted, next_key, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row r, column c is byte r+4c.
  function automatic logic [BLOCK_W-1:0] sub_shift(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BLOCK_W-1:0] key_expand(input logic [BLOCK_W-1:0] k,
                                                   input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round datapath; the final round skips MixColumns.
  always_comb begin
    shifted   = sub_shift(blk_q);
    next_key  = key_expand(rkey_q, rcon(round_q));
    round_out = ((round_q == ROUND_W'(LAST_ROUND)) ? shifted : mix_columns(shifted)) ^ next_key;
  end

  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    busy_d  = busy;
    done_d  = 1'b0;
    ct_d    = ciphertext;
    fault_d = fault_flag;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          blk_d   = plaintext ^ key;
          rkey_d  = key;
          round_d = ROUND_W'(1);
          busy_d  = 1'b1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (start) fault_d = 1'b1;
        blk_d   = round_out;
        rkey_d  = next_key;
        round_d = round_q + ROUND_W'(1);
        if (round_q == ROUND_W'(LAST_ROUND)) begin
          ct_d    = round_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          round_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= IDLE;
      blk_q      <= '0;
      rkey_q     <= '0;
      round_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
      fault_flag <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      blk_q      <= blk_d;
      rkey_q     <= rkey_d;
      round_q    <= round_d;
      busy       <= busy_d;
      done       <= done_d;
      ciphertext <= ct_d;
      fault_flag <= fault_d;
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: transaction-level AES-128 reference plus a per-cycle
// comparison of every output, pinned by FIPS-197 known-answer vectors.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key, plaintext;
  logic         busy, done, fault_flag;
  logic [127:0] ciphertext;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0] sb [256];

  logic         m_busy = 1'b0, m_done = 1'b0, m_fault = 1'b0;
  logic [127:0] m_ct = '0, m_pend = '0;
  int           m_left = 0;

  aes_top dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .plaintext(plaintext),
    .busy(busy), .done(done), .ciphertext(ciphertext), .fault_flag(fault_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = p[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = sb[s[r][c]];
      for (int r = 1; r < 4; r++) begin
        for (int c = 0; c < 4; c++) t[c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++) s[r][c] = t[c];
      end
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[r][c];
          for (int r = 0; r < 4; r++)
            s[r][c] = gm(t[r], 8'h02) ^ gm(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Transaction model: a run accepted in idle completes ten edges later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ct <= '0; m_fault <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (start) m_fault <= 1'b1;
        if (m_left == 1) begin
          m_ct   <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_pend <= aes_ref(key, plaintext);
        m_busy <= 1'b1;
        m_left <= 10;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("done", 128'(done), 128'(m_done));
      check("fault_flag", 128'(fault_flag), 128'(m_fault));
      check("ciphertext", ciphertext, m_ct);
    end
  end

  // Pulse start now, scramble inputs after the accepting edge, expect done 10 edges later.
  task automatic run(input logic [127:0] k, input logic [127:0] p,
                     input logic [127:0] exp, input bit have_exp);
    int n;
    bit got;
    start = 1'b1; key = k; plaintext = p;
    @(posedge clk); #2;
    start = 1'b0; key = rnd128(); plaintext = rnd128();
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); n++; #1;
      if (done) got = 1'b1;
    end
    check("latency", 128'(n), 128'(10));
    if (have_exp) check("vector", ciphertext, exp);
  endtask

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] k1, p1, got_ct;
    logic [7:0]   inv, x8;
    int           cnt;

    rst = 1'b1; start = 1'b0; key = '0; plaintext = '0;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gm(x8, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    check("ref_sbox_00", 128'(sb[0]), 128'(8'h63));
    check("ref_sbox_53", 128'(sb[8'h53]), 128'(8'hed));
    check("ref_c1", aes_ref(K_C1, P_C1), C_C1);
    check("ref_b", aes_ref(K_B, P_B), C_B);
    check("ref_zero", aes_ref('0, '0), C_Z);

    #1 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Known answers back to back, each start issued in the done-high cycle.
    run(K_C1, P_C1, C_C1, 1'b1);
    run(K_B, P_B, C_B, 1'b1);
    run('0, '0, C_Z, 1'b1);
    @(posedge clk); #2;
    run(K_B, P_B, C_B, 1'b1);

    for (int i = 0; i < 12; i++) begin
      k1 = rnd128(); p1 = rnd128();
      run(k1, p1, aes_ref(k1, p1), 1'b1);
    end

    // Misuse: second start on the fourth edge of a run.
    k1 = rnd128(); p1 = rnd128();
    start = 1'b1; key = k1; plaintext = p1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; key = rnd128(); plaintext = rnd128();
    @(posedge clk); #2 start = 1'b0;
    cnt = 0; got_ct = '0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) begin cnt++; got_ct = ciphertext; end
    end
    check("misuse_done_count", 128'(cnt), 128'(1));
    check("misuse_result", got_ct, aes_ref(k1, p1));
    check("misuse_fault", 128'(fault_flag), 128'(1));

    // Abort mid-run: outputs clear asynchronously, including the sticky fault.
    start = 1'b1; key = rnd128(); plaintext = rnd128();
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_ct", ciphertext, '0);
    check("abort_fault", 128'(fault_flag), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    run(K_C1, P_C1, C_C1, 1'b1);

    // Start held high: re-accepted on each idle edge, faults while running.
    @(posedge clk); #1;
    start = 1'b1; key = rnd128(); plaintext = rnd128();
    cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    start = 1'b0;
    check("held_done_count", 128'(cnt), 128'(2));
    check("held_fault", 128'(fault_flag), 128'(1));
    repeat (14) @(posedge clk);
    #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
